spikey_spi_ctrl: RTL and testbench
==================================

# spikey_spi_ctrl

SPI master transaction controller that sequences the shared `spikey_spi` FCLK divider.
- Accepts one word per command on a valid/ready interface and selects a divider tap per command.
- Restarts the divider through `rst_div`, derives SCK half-period ticks from the selected `fclk_div` bit, and shifts a full-duplex word in SPI mode 0.
- Returns the received word on a one-cycle response strobe. Sits between the TileLink-side register logic and the divider/pads.

## Interface
- `DATA_W`, 8: bits per transaction, 2..32.
- `FCLK` in 1: single clock, all logic posedge.
- `RST_N` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_data` in DATA_W: word to transmit.
- `cmd_div_sel` in 2: divider tap k; SCK half-period = 2^k FCLK cycles.
- `cmd_keep_cs` in 1: leave CS_N low after this word.
- `rsp_valid` out 1: one-cycle pulse, received word valid.
- `rsp_data` out DATA_W: received word, held until next `rsp_valid`.
- `busy` out 1: high in any state other than IDLE.
- `rst_div` out 1: registered restart pulse to the divider.
- `fclk_div` in 4: divider counter from `spikey_spi`.
- `SCK` out 1, `MOSI` out 1, `CS_N` out 1: pad outputs, all registered.
- `MISO` in 1: pad input, sampled on rising SCK.

## Operation
- Reset values: `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0, `rst_div`=0, `SCK`=0, `MOSI`=0, `CS_N`=1, state=IDLE.
- tick = `fclk_div[k]` != `prev_bit`.
  - `prev_bit` is registered every cycle and forced to 0 while `rst_div`=1.
  - `k` is latched at accept.
- States:
  - **IDLE**:
    - On `cmd_valid & cmd_ready`, latch data, k and keep flag.
    - Drive `rst_div`=1 for exactly the next cycle.
    - Drive `CS_N`=0, `SCK`=0, `MOSI`=first bit.
    - Go to LEAD.
  - **LEAD**: wait for the first tick, then go to SHIFT.
  - **SHIFT**: each tick toggles `SCK`.
    - Rising edge: sample `MISO` into the rx shifter.
    - Falling edge: present the next tx bit on `MOSI`.
    - After 2·DATA_W ticks `SCK` is back to 0; go to TRAIL.
  - **TRAIL**:
    - On the next tick: pulse `rsp_valid` and update `rsp_data`.
    - Set `CS_N`=1 unless keep flag is set.
    - Return to IDLE.
- Bit order is MSB first.
- With keep flag set, `CS_N` stays 0 in IDLE until the next command without keep completes, or until reset.
- `cmd_valid` while busy is ignored; the command is not consumed.
- `cmd_valid` on the same cycle `rsp_valid` pulses is accepted (IDLE already re-entered).
- Reset mid-transfer:
  - All outputs take reset values immediately, asynchronously.
  - The partial word is discarded.
  - No `rsp_valid`.

## Timing
- Ticks are exactly 2^k FCLK cycles apart.
  - Accept at edge 0; `rst_div` high in cycle 1; divider reads 0 in cycle 2.
  - First tick in cycle 2+2^k.
- Ticks per transaction: 1 (LEAD) + 2·DATA_W (SHIFT) + 1 (TRAIL).
- `rsp_valid` and `cmd_ready` rise the cycle after the last tick.
- DATA_W=8, k=0: last tick cycle 20, `rsp_valid` cycle 21.
- DATA_W=8, k=3: last tick cycle 146, `rsp_valid` cycle 147.
- `SCK` period is 2^(k+1) cycles with 50% duty.
- `MOSI` changes only on falling SCK, or at CS assertion for bit 0.

## Configuration
- `SPIKEY_SPI_LSB_FIRST_EN`
  - Defined: adds input `cmd_lsb_first` (1 bit), latched at accept. When 1, both tx and rx shift LSB first.
  - Undefined: the port is absent and all transfers are MSB first.

## Structure
- Package `spikey_spi_pkg` holds:
  - State enum (IDLE, LEAD, SHIFT, TRAIL).
  - `DIV_W`=4.
  - Bit-counter width function `$clog2(2*DATA_W+1)`.
- The divider `spikey_spi` stays external; this block only drives `rst_div` and reads `fclk_div`.
- One sub-module, `spikey_spi_shreg`: DATA_W-bit tx/rx shift register with load, shift-on-edge and direction select.

## Test plan
- k=0, `cmd_data`=0xA5, MISO looped to MOSI -> 8 SCK pulses of period 2, `rsp_data`=0xA5, `rsp_valid` in cycle 21, `CS_N` back to 1.
- k=3, `cmd_data`=0x3C, MISO tied 1 -> SCK period 16, `rsp_data`=0xFF, `rsp_valid` in cycle 147.
- Two commands: first with `cmd_keep_cs`=1 (0x12), second without (0x34) -> `CS_N` low continuously through both, rises after the second `rsp_valid`.
- `cmd_valid` held high across a transfer -> exactly one accept per IDLE. Second command accepted in the `rsp_valid` cycle.
- `RST_N` low at the 4th SHIFT tick -> immediately `CS_N`=1, `SCK`=0, `busy`=0, no `rsp_valid`. Next command completes normally.
- Macro defined, `cmd_lsb_first`=1, 0x01 looped back -> first MOSI bit 1, `rsp_data`=0x01.

Source files
------------

// File: rtl/spikey_spi_pkg.sv
// spikey_spi_pkg: shared constants for the spikey_spi transaction controller.
// State encoding is kept as plain localparams so legacy users can compare raw codes.
package spikey_spi_pkg;

  localparam int DIV_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  // Enough bits to count every SCK edge of a word plus one.
  function automatic int cnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spikey_spi_shreg.sv
// spikey_spi_shreg: tx/rx shift register pair with load and a latched direction select.
module spikey_spi_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              lsb_first_i,
  input  logic              tx_shift_i,
  input  logic              rx_shift_i,
  input  logic              rx_bit_i,
  output logic              tx_next_o,
  output logic [DATA_W-1:0] rx_data_o
);

  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              lsb_q, lsb_d;

  // Next-state for load, transmit shift and receive shift.
  always_comb begin
    tx_d  = tx_q;
    rx_d  = rx_q;
    lsb_d = lsb_q;
    if (load_i) begin
      tx_d  = load_data_i;
      rx_d  = {DATA_W{1'b0}};
      lsb_d = lsb_first_i;
    end else begin
      if (tx_shift_i) begin
        tx_d = lsb_q ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
      end else begin
        tx_d = tx_q;
      end
      if (rx_shift_i) begin
        rx_d = lsb_q ? {rx_bit_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], rx_bit_i};
      end else begin
        rx_d = rx_q;
      end
    end
  end

  // Shift register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_q  <= {DATA_W{1'b0}};
      rx_q  <= {DATA_W{1'b0}};
      lsb_q <= 1'b0;
    end else begin
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      lsb_q <= lsb_d;
    end
  end

  // Bit that follows the one currently on MOSI.
  assign tx_next_o = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
  assign rx_data_o = rx_q;

endmodule

// File: rtl/spikey_spi_ctrl.sv
// spikey_spi_ctrl: SPI mode-0 master sequencing the external spikey_spi FCLK divider.
// Defining SPIKEY_SPI_LSB_FIRST_EN adds cmd_lsb_first for per-command LSB-first transfers.
module spikey_spi_ctrl
  import spikey_spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              FCLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [1:0]        cmd_div_sel,
  input  logic              cmd_keep_cs,
`ifdef SPIKEY_SPI_LSB_FIRST_EN
  input  logic              cmd_lsb_first,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              rst_div,
  input  logic [DIV_W-1:0]  fclk_div,
  output logic              SCK,
  output logic              MOSI,
  output logic              CS_N,
  input  logic              MISO
);

  localparam int CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              keep_q, keep_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prev_q, prev_d;
  logic              rst_div_q, rst_div_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              lsb_s, tick_s, load_s, tx_shift_s, rx_shift_s, tx_next_s;
  logic [DATA_W-1:0] rx_word_s;

`ifdef SPIKEY_SPI_LSB_FIRST_EN
  assign lsb_s = cmd_lsb_first;
`else
  assign lsb_s = 1'b0;
`endif

  // The divider output is garbage while it is being restarted, so no tick then.
  assign tick_s = (fclk_div[k_q] != prev_q) & ~rst_div_q;
  assign prev_d = rst_div_q ? 1'b0 : fclk_div[k_q];

  spikey_spi_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk_i       (FCLK),
    .rst_ni      (RST_N),
    .load_i      (load_s),
    .load_data_i (cmd_data),
    .lsb_first_i (lsb_s),
    .tx_shift_i  (tx_shift_s),
    .rx_shift_i  (rx_shift_s),
    .rx_bit_i    (MISO),
    .tx_next_o   (tx_next_s),
    .rx_data_o   (rx_word_s)
  );

  // Transaction sequencing: accept, lead-in, SCK edges, trail-out.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    keep_d      = keep_q;
    cnt_d       = cnt_q;
    rst_div_d   = 1'b0;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    load_s      = 1'b0;
    tx_shift_s  = 1'b0;
    rx_shift_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          load_s    = 1'b1;
          k_d       = cmd_div_sel;
          keep_d    = cmd_keep_cs;
          cnt_d     = {CNT_W{1'b0}};
          rst_div_d = 1'b1;
          cs_n_d    = 1'b0;
          sck_d     = 1'b0;
          mosi_d    = lsb_s ? cmd_data[0] : cmd_data[DATA_W-1];
          state_d   = ST_LEAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (tick_s) state_d = ST_SHIFT;
        else        state_d = ST_LEAD;
      end
      ST_SHIFT: begin
        if (tick_s) begin
          sck_d = ~sck_q;
          cnt_d = cnt_q + CNT_W'(1);
          if (sck_q) begin
            tx_shift_s = 1'b1;
            if (cnt_q == LAST_CNT) state_d = ST_TRAIL;
            else                   mosi_d  = tx_next_s;
          end else begin
            rx_shift_s = 1'b1;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_TRAIL: begin
        if (tick_s) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_word_s;
          cs_n_d      = ~keep_q;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_TRAIL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller and pad registers.
  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      k_q         <= 2'd0;
      keep_q      <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      prev_q      <= 1'b0;
      rst_div_q   <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      keep_q      <= keep_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      rst_div_q   <= rst_div_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rst_div   = rst_div_q;
  assign SCK       = sck_q;
  assign MOSI      = mosi_q;
  assign CS_N      = cs_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spikey_spi_ctrl.sv
// tb_spikey_spi_ctrl: directed and randomized checks of spikey_spi_ctrl with a divider model.
module tb_spikey_spi_ctrl;

  logic       FCLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [1:0] cmd_div_sel = 2'd0;
  logic       cmd_keep_cs = 1'b0;
`ifdef SPIKEY_SPI_LSB_FIRST_EN
  logic       cmd_lsb_first = 1'b0;
`endif
  logic       cmd_ready, rsp_valid, busy, rst_div, SCK, MOSI, CS_N, MISO;
  logic [7:0] rsp_data;
  logic [3:0] div_q = 4'd9;

  int checks = 0;
  int errors = 0;

  // Reference-side state: what the pads should show, tracked independently of the RTL.
  logic       loop_mode = 1'b1;
  logic       lsb_mode = 1'b0;
  logic [7:0] rx_pat = 8'h00;
  logic [3:0] idx = 4'd0;
  logic [7:0] cap = 8'h00;
  logic       sck_prev = 1'b0, mosi_prev = 1'b0;
  bit         cs_hold = 1'b0;
  int rises = 0, cs_bad = 0, mosi_bad = 0, per_bad = 0, acc_cnt = 0, rsp_cnt = 0, cs_gap = 0;
  int ncyc = 0, last_rise = 0, cur_half = 1;

  spikey_spi_ctrl #(.DATA_W(8)) dut (
    .FCLK(FCLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_div_sel(cmd_div_sel), .cmd_keep_cs(cmd_keep_cs),
`ifdef SPIKEY_SPI_LSB_FIRST_EN
    .cmd_lsb_first(cmd_lsb_first),
`endif
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .rst_div(rst_div),
    .fclk_div(div_q), .SCK(SCK), .MOSI(MOSI), .CS_N(CS_N), .MISO(MISO)
  );

  always #5 FCLK = ~FCLK;

  // External divider: free-running counter cleared by rst_div.
  always @(posedge FCLK) div_q <= rst_div ? 4'd0 : div_q + 4'd1;

  // Slave model: loopback or a fixed pattern, advancing one bit per rising SCK.
  assign MISO = loop_mode ? MOSI : (lsb_mode ? rx_pat[idx[2:0]] : rx_pat[3'd7 - idx[2:0]]);

  // Pad monitor sampled mid-cycle.
  always @(negedge FCLK) begin
    ncyc <= ncyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cnt <= acc_cnt + 1;
      idx <= 4'd0;
      cap <= 8'h00;
      rises <= 0;
    end else if (SCK && !sck_prev) begin
      cap <= {cap[6:0], MOSI};
      idx <= idx + 4'd1;
      rises <= rises + 1;
      last_rise <= ncyc;
      if (CS_N !== 1'b0) cs_bad <= cs_bad + 1;
      if (rises > 0 && (ncyc - last_rise) != 2 * cur_half) per_bad <= per_bad + 1;
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (SCK && sck_prev && MOSI !== mosi_prev) mosi_bad <= mosi_bad + 1;
    if (cs_hold && CS_N !== 1'b0) cs_gap <= cs_gap + 1;
    sck_prev <= SCK;
    mosi_prev <= MOSI;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  // Offer a command at posedge+1 and check the accept-cycle outputs.
  task automatic start(input logic [7:0] d, input logic [1:0] k, input logic keep,
                       input logic lsb, input logic loop, input logic [7:0] rxp, input bit hold);
    chk("ready_before_accept", cmd_ready, 1);
    cmd_data = d; cmd_div_sel = k; cmd_keep_cs = keep; cmd_valid = 1'b1;
`ifdef SPIKEY_SPI_LSB_FIRST_EN
    cmd_lsb_first = lsb;
`endif
    lsb_mode = lsb; loop_mode = loop; rx_pat = rxp; cur_half = 1 << k;
    @(posedge FCLK); #1;
    if (!hold) cmd_valid = 1'b0;
    chk("rst_div_pulse", rst_div, 1);
    chk("busy_after_accept", busy, 1);
    chk("cs_asserted", CS_N, 0);
    chk("mosi_first_bit", MOSI, lsb ? d[0] : d[7]);
  endtask

  // Wait (bounded) for rsp_valid and compare against the reference model.
  task automatic finish(input logic [7:0] d, input logic [1:0] k, input logic keep,
                        input logic lsb, input logic loop, input logic [7:0] rxp, input int r0);
    int cyc;
    cyc = 1;
    while (cyc < 4000 && rsp_valid !== 1'b1) begin
      @(posedge FCLK); #1;
      cyc++;
    end
    chk("rsp_cycle", cyc, 3 + 18 * (1 << k));
    chk("rsp_data", rsp_data, loop ? d : rxp);
    chk("mosi_stream", cap, lsb ? rev8(d) : d);
    chk("sck_rises", rises, 8);
    chk("cs_after_rsp", CS_N, keep ? 0 : 1);
    chk("ready_in_rsp_cycle", cmd_ready, 1);
    chk("sck_idle_low", SCK, 0);
    chk("rsp_pulse_count", rsp_cnt - r0, 0);
    chk("pad_rule_violations", cs_bad + mosi_bad + per_bad, 0);
  endtask

  task automatic do_txn(input logic [7:0] d, input logic [1:0] k, input logic keep,
                        input logic lsb, input logic loop, input logic [7:0] rxp);
    int r0;
    r0 = rsp_cnt;
    start(d, k, keep, lsb, loop, rxp, 1'b0);
    finish(d, k, keep, lsb, loop, rxp, r0);
    @(posedge FCLK); #1;
    chk("rsp_valid_one_cycle", rsp_valid, 0);
    chk("rsp_data_held", rsp_data, loop ? d : rxp);
    chk("rsp_counted_once", rsp_cnt - r0, 1);
  endtask

  initial begin
    int a0, r0;
    logic [7:0] rd, rp;
    logic [1:0] rk;
    logic       rl, rlsb;

    repeat (3) @(posedge FCLK);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rst_div", rst_div, 0);
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_cs_n", CS_N, 1);
    RST_N = 1'b1;
    @(posedge FCLK); #1;

    do_txn(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00);
    do_txn(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 8'hFF);

    // Keep-CS pair: CS_N must stay low from first accept until the second response.
    r0 = rsp_cnt;
    start(8'h12, 2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    finish(8'h12, 2'd0, 1'b1, 1'b0, 1'b1, 8'h00, r0);
    cs_hold = 1'b1;
    r0 = rsp_cnt + 1;
    start(8'h34, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    finish(8'h34, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00, r0);
    cs_hold = 1'b0;
    chk("cs_held_low_across_keep", cs_gap, 0);
    @(posedge FCLK); #1;

    // cmd_valid held across a transfer; second accept lands in the rsp_valid cycle.
    a0 = acc_cnt;
    r0 = rsp_cnt;
    start(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    finish(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, r0);
    r0 = rsp_cnt + 1;
    start(8'hC3, 2'd0, 1'b0, 1'b0, 1'b0, 8'h69, 1'b0);
    finish(8'hC3, 2'd0, 1'b0, 1'b0, 1'b0, 8'h69, r0);
    chk("accepts_with_held_valid", acc_cnt - a0, 2);
    @(posedge FCLK); #1;

    // Reset during the 4th SHIFT tick (k=1: ticks at cycles 4,6,8,10,12).
    r0 = rsp_cnt;
    start(8'h96, 2'd1, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0);
    repeat (11) begin @(posedge FCLK); #1; end
    chk("sck_before_abort", SCK, 1);
    RST_N = 1'b0;
    #1;
    chk("abort_cs_n", CS_N, 1);
    chk("abort_sck", SCK, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_mosi", MOSI, 0);
    #2 RST_N = 1'b1;
    repeat (40) begin @(posedge FCLK); #1; end
    chk("abort_no_rsp", rsp_cnt - r0, 0);
    chk("abort_cs_stays_high", CS_N, 1);
    do_txn(8'h4E, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00);

`ifdef SPIKEY_SPI_LSB_FIRST_EN
    do_txn(8'h01, 2'd0, 1'b0, 1'b1, 1'b1, 8'h00);
    do_txn(8'hB2, 2'd1, 1'b0, 1'b1, 1'b0, 8'h1D);
`endif

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      rp = 8'($urandom);
      rk = 2'($urandom_range(0, 2));
      rl = 1'($urandom_range(0, 1));
`ifdef SPIKEY_SPI_LSB_FIRST_EN
      rlsb = 1'($urandom_range(0, 1));
`else
      rlsb = 1'b0;
`endif
      do_txn(rd, rk, 1'b0, rlsb, rl, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
